// File: rtl/seq_buffer.sv
// Store-and-browse buffer for converted words: circular storage with a
// user-steerable cursor, reject/overwrite full policy and sticky error flags.
module seq_buffer #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 10,
    parameter int OVERWRITE = 0,
    parameter int IDX_W     = $clog2(DEPTH),
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_err,
    input  logic             nxt,
    input  logic             prv,
    output logic [WIDTH-1:0] rd_data,
    output logic [IDX_W-1:0] rd_index,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic [1:0]       err_out
);

    localparam int AW = IDX_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam bit OVW = (OVERWRITE != 0);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] cursor;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       err;

    logic [IDX_W-1:0] rd_addr, wr_addr, head_inc, last_idx, cur_nav, cur_next;
    logic [CNT_W-1:0] cnt_dec;
    logic             is_full, is_empty, wr_ok, wr_append, wr_ovw, mem_we;
    logic [IDX_W-1:0] mem_addr;

    // Sum of two in-range indices is below 2*DEPTH, so one conditional subtract wraps it.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [AW-1:0] s;
        s = a + b;
        if (s >= AW'(DEPTH))
            s = s - AW'(DEPTH);
        return s[IDX_W-1:0];
    endfunction

    always_comb begin
        is_full   = (cnt == DEPTH_C);
        is_empty  = (cnt == '0);
        cnt_dec   = cnt - CNT_W'(1);
        last_idx  = IDX_W'(cnt_dec);
        rd_addr   = wrap_add(AW'(head), AW'(cursor));
        wr_addr   = wrap_add(AW'(head), AW'(cnt));
        head_inc  = wrap_add(AW'(head), AW'(1));
        wr_ok     = wr_valid && !wr_err;
        wr_append = wr_ok && !is_full;
        wr_ovw    = wr_ok && is_full && OVW;
        mem_we    = reset_n && !clear && (wr_append || wr_ovw);
        mem_addr  = wr_append ? wr_addr : head;

        cur_nav = cursor;
        if (!is_empty && (nxt != prv)) begin
            if (nxt)
                cur_nav = (cursor == last_idx) ? '0 : cursor + IDX_W'(1);
            else
                cur_nav = (cursor == '0) ? last_idx : cursor - IDX_W'(1);
        end
        // Overwrite retires the oldest entry, so the cursor slides down to stay on its word.
        cur_next = cur_nav;
        if (wr_ovw && cur_nav != '0)
            cur_next = cur_nav - IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            head   <= '0;
            cnt    <= '0;
            cursor <= '0;
            err    <= 2'b00;
        end else begin
            cursor <= cur_next;
            if (wr_valid) begin
                if (wr_err)
                    err[0] <= 1'b1;
                else if (wr_append)
                    cnt <= cnt + CNT_W'(1);
                else if (wr_ovw)
                    head <= head_inc;
                else
                    err[1] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_addr] <= wr_data;
    end

    assign rd_data  = is_empty ? '0 : mem[rd_addr];
    assign rd_index = cursor;
    assign count    = cnt;
    assign full     = is_full;
    assign empty    = is_empty;
    assign err_out  = err;

endmodule

// File: doc/seq_buffer.md
Name: seq_buffer

Overview:
- Parametrised sequence store-and-browse buffer that sits between the input FSM (producer of converted words with an error flag) and the seven-segment display path.
- Captures up to DEPTH words in arrival order.
- Lets the user step forward and backward through the stored words with debounced button pulses.
- Provides selectable overflow handling (reject or overwrite-oldest) and sticky error reporting.

Parameters:
- WIDTH, 32, bit width of each stored word.
- DEPTH, 10, number of entries; any value >= 2.
- OVERWRITE, 0, full-buffer policy: 0 = reject new word and flag overflow; 1 = discard oldest entry and store the new one.
- IDX_W, $clog2(DEPTH), derived, width of the index outputs.
- CNT_W, $clog2(DEPTH+1), derived, width of the count output.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- clear  in  1  one-cycle pulse that starts a new sequence (empties the buffer, clears errors).
- wr_valid  in  1  one-cycle pulse: producer result available this cycle.
- wr_data  in  WIDTH  producer word, sampled when wr_valid=1.
- wr_err  in  1  producer error qualifier, sampled when wr_valid=1.
- nxt  in  1  one-cycle pulse: move cursor forward.
- prv  in  1  one-cycle pulse: move cursor backward.
- rd_data  out  WIDTH  word at the cursor; 0 when empty.
- rd_index  out  IDX_W  logical cursor position, where 0 = oldest entry.
- count  out  CNT_W  number of stored entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- err_out  out  2  sticky flags: bit0 = producer error, bit1 = overflow reject.

Behaviour:
- Storage: circular memory with head pointer (oldest entry, physical) and count. Logical entry i lives at physical address (head+i) mod DEPTH. All pointer arithmetic wraps explicitly at DEPTH, not at a power of two.
- Reset (reset_n=0 at a clock edge):
  - head=0, count=0, cursor=0, err_out=2'b00.
  - Resulting outputs: rd_data=0, rd_index=0, empty=1, full=0.
  - Reset has priority over every other input.
  - Memory contents are not cleared; they are unobservable while the buffer is empty.
- clear=1: same effect as reset, one-cycle latency. clear has priority over wr_valid, nxt and prv in the same cycle.
- Write cases (all take effect at the next edge):
  - wr_valid=1, wr_err=1: nothing is stored; err_out[0]<=1.
  - wr_valid=1, wr_err=0, count<DEPTH: mem[(head+count) mod DEPTH]<=wr_data; count<=count+1.
  - wr_valid=1, wr_err=0, count==DEPTH, OVERWRITE=0: word is dropped; err_out[1]<=1; state otherwise unchanged.
  - wr_valid=1, wr_err=0, count==DEPTH, OVERWRITE=1: mem[head]<=wr_data; head<=head+1 (wrapping); count unchanged. The cursor keeps tracking the same word: decrement it if >0; if it is 0 it stays at 0, which now shows the new oldest entry.
- Navigation (always uses the pre-write count):
  - Buffer empty: cursor stays 0.
  - nxt only: cursor <= (cursor==count-1) ? 0 : cursor+1.
  - prv only: cursor <= (cursor==0) ? count-1 : cursor-1.
  - nxt and prv together: no move.
- Navigation and overwrite in the same cycle: apply navigation first, then the overwrite decrement rule to the result.
- Read path is combinational from registered state: rd_data = empty ? 0 : mem[(head+cursor) mod DEPTH]. A write or move is therefore visible on rd_data in the cycle after its edge.
- err_out bits are sticky; only reset or clear returns them to 0.
- rd_index = cursor; full and empty are decoded from count.

Test Plan:
- DEPTH=10: reset, write 0x11, 0x22, 0x33 → count=3, rd_index=0, rd_data=0x11; three nxt pulses → rd_data 0x22, 0x33, 0x11 (wrap).
- Same contents, cursor at 0, one prv → rd_index=2, rd_data=0x33; nxt and prv in the same cycle → no move.
- DEPTH=4, OVERWRITE=0: write 1, 2, 3, 4, 5 → count=4, full=1, err_out=2'b10, entries 1, 2, 3, 4; fifth word never visible.
- DEPTH=4, OVERWRITE=1: write 1–4, navigate to rd_index=2 (value 3), write 5 → rd_index=1, rd_data=3, count=4, logical entries 2, 3, 4, 5, err_out=0.
- wr_valid with wr_err=1 → err_out=2'b01, count unchanged; then clear in the same cycle as a valid write → count=0, empty=1, err_out=0, word not stored.
- Mid-sequence (count=3, cursor=2, err_out=2'b01), reset_n=0 for one edge → count=0, rd_index=0, rd_data=0, err_out=0, empty=1; next write appears at rd_index 0.
